int_source_ctrl: RTL

- Interrupt source controller directly upstream of the pipelined CPU; produces the CPU's `INT` level and `cause` word.
- Debounces push-buttons, runs a periodic timer, latches per-source pending bits and applies a mask.
- Picks the highest-priority source and holds a request until the CPU takes it.
- Blocks further requests until the CPU's `mret` (0x30200073) retires.

---
 rtl/int_source_ctrl_pkg.sv | 10 +
 rtl/int_source_ctrl_btn_debounce.sv | 35 +++
 rtl/int_source_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/int_source_ctrl_pkg.sv
// int_source_ctrl_pkg: shared constants and FSM encoding for the interrupt source controller
package int_source_ctrl_pkg;
    localparam int N_BTN_DEF = 4;
    localparam int SRC_TMR = N_BTN_DEF;
    localparam int CAUSE_INT_BIT = 31;
    localparam logic [1:0] CFG_ADDR_MASK = 2'd0;
    localparam logic [1:0] CFG_ADDR_PERIOD = 2'd1;
    localparam logic [1:0] CFG_ADDR_PCLR = 2'd2;
    typedef enum logic [1:0] {IDLE, REQ, SERV, GAP} state_t;
endpackage

// File: rtl/int_source_ctrl_btn_debounce.sv
// btn_debounce: synchronizes one raw button and emits a pulse when its debounced level rises
module btn_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);
    localparam int CW = $clog2(DEB_CYC + 1);
    logic [1:0] sync;
    logic [CW-1:0] cnt;
    logic stable;
    // Two-flop synchronizer, then count how long the synced level disagrees with the accepted level
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= '0;
            cnt <= '0;
            stable <= 1'b0;
            rise <= 1'b0;
        end else begin
            sync <= {sync[0], btn};
            rise <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYC - 1)) begin
                cnt <= '0;
                stable <= sync[1];
                rise <= sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/int_source_ctrl.sv
// int_source_ctrl: debounced buttons plus periodic timer feeding a masked, prioritized CPU interrupt request
module int_source_ctrl
    import int_source_ctrl_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEF,
    parameter int DEB_CYC = 16,
    parameter int TMR_W = 32,
    parameter logic [TMR_W-1:0] TMR_DEFAULT = 32'd50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  btn,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [31:0]       cfg_wdata,
    input  logic              int_take,
    input  logic              int_ret,
    output logic              INT,
    output logic [31:0]       cause,
    output logic [N_BTN:0]    pending,
    output logic              in_service
);
    localparam int IW = $clog2(N_BTN + 1);
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN:0] mask, elig, clr;
    logic [TMR_W-1:0] period, count;
    logic tmr_evt, take;
    logic [IW-1:0] win, sel;
    state_t state;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .clk(clk),
            .rst(rst),
            .btn(btn[i]),
            .rise(btn_rise[i])
        );
    end

    assign elig = pending & mask;
    assign tmr_evt = (period != '0) && (count == period - 1'b1);
    assign take = (state == REQ) && int_take && elig[sel];

    // Priority pick: timer first, then the lowest-numbered button
    always_comb begin
        win = IW'(0);
        for (int i = N_BTN - 1; i >= 0; i--) if (elig[i]) win = IW'(i);
        if (elig[N_BTN]) win = IW'(SRC_TMR);
        clr = (cfg_we && cfg_addr == CFG_ADDR_PCLR) ? cfg_wdata[N_BTN:0] : '0;
        clr = take ? (clr | ((N_BTN+1)'(1) << sel)) : clr;
    end

    // Config registers and free-running timer; a period write restarts the count
    always_ff @(posedge clk) begin
        if (!rst) begin
            mask <= '1;
            period <= TMR_DEFAULT;
            count <= '0;
        end else begin
            if (cfg_we && cfg_addr == CFG_ADDR_MASK) mask <= cfg_wdata[N_BTN:0];
            if (cfg_we && cfg_addr == CFG_ADDR_PERIOD) period <= cfg_wdata[TMR_W-1:0];
            count <= ((cfg_we && cfg_addr == CFG_ADDR_PERIOD) || period == '0 || tmr_evt) ? '0 : count + 1'b1;
        end
    end

    // Pending bits: new events win over clears arriving in the same cycle
    always_ff @(posedge clk) begin
        if (!rst) pending <= '0;
        else pending <= (pending & ~clr) | {tmr_evt, btn_rise};
    end

    // Request handshake FSM with registered INT, cause and in_service
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            INT <= 1'b0;
            cause <= '0;
            in_service <= 1'b0;
            sel <= '0;
        end else begin
            case (state)
                IDLE: if (elig != '0) begin
                    sel <= win;
                    cause <= 32'(win) | (32'd1 << CAUSE_INT_BIT);
                    INT <= 1'b1;
                    state <= REQ;
                end
                REQ: if (!elig[sel]) begin
                    INT <= 1'b0;
                    state <= IDLE;
                end else if (int_take) begin
                    INT <= 1'b0;
                    in_service <= 1'b1;
                    state <= SERV;
                end
                SERV: if (int_ret) begin
                    in_service <= 1'b0;
                    state <= GAP;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
